// File: rtl/bridge_rx_pkg.sv
// Shared constants and types for the ASCII-to-bus command receiver.
package bridge_rx_pkg;

  localparam logic [7:0] CH_R  = 8'h52;  // 'R' : start of read command
  localparam logic [7:0] CH_W  = 8'h57;  // 'W' : start of write command
  localparam logic [7:0] CH_CR = 8'h0D;  // carriage return terminator
  localparam logic [7:0] CH_LF = 8'h0A;  // line feed terminator

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_TERM = 2'd3
  } state_t;

  // True for either accepted line terminator.
  function automatic logic is_term(input logic [7:0] b);
    return (b == CH_CR) || (b == CH_LF);
  endfunction

endpackage

// File: rtl/bridge_rx_if.sv
// Bus-side transaction signals produced by the command receiver.
interface bridge_rx_if;
  logic [15:0] addr_o;
  logic [15:0] wdata_o;
  logic [15:0] rdata_o;
  logic        rw_o;
  logic        valid_o;
  logic        err_o;

  modport master (output addr_o, wdata_o, rdata_o, rw_o, valid_o, err_o);
  modport slave  (input  addr_o, wdata_o, rdata_o, rw_o, valid_o, err_o);
endinterface

// File: rtl/bridge_rx_hex_char_decoder.sv
// Combinational ASCII hex digit classifier and nibble decoder.
module hex_char_decoder (
  input  logic [7:0] char_in,
  output logic       is_hex,
  output logic [3:0] nibble
);

  logic [7:0] offset;

  // Classify the byte and map 0-9 / A-F / a-f onto a 4-bit value.
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    offset = 8'h00;
    if ((char_in >= 8'h30) && (char_in <= 8'h39)) begin
      is_hex = 1'b1;
      offset = char_in - 8'h30;
      nibble = offset[3:0];
    end else if ((char_in >= 8'h41) && (char_in <= 8'h46)) begin
      is_hex = 1'b1;
      offset = char_in - 8'h37;
      nibble = offset[3:0];
    end else if ((char_in >= 8'h61) && (char_in <= 8'h66)) begin
      is_hex = 1'b1;
      offset = char_in - 8'h57;
      nibble = offset[3:0];
    end else begin
      is_hex = 1'b0;
      nibble = 4'h0;
    end
  end

endmodule

// File: rtl/bridge_rx.sv
// Parses "R aaaa <term>" / "W aaaa dddd <term>" ASCII commands into bus transactions.
module bridge_rx
  import bridge_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  bridge_rx_if.master bus
);

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic        rw, rw_n;
  logic [15:0] addr_sh, addr_sh_n;
  logic [15:0] data_sh, data_sh_n;
  logic        issue, err;
  logic        is_hex;
  logic [3:0]  nibble;

  hex_char_decoder u_hex (
    .char_in (data_i),
    .is_hex  (is_hex),
    .nibble  (nibble)
  );

  // Head of the read-data chain is always zero.
  assign bus.rdata_o = 16'h0000;

  // Next-state, shift-register update and strobe decode for each accepted byte.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rw_n      = rw;
    addr_sh_n = addr_sh;
    data_sh_n = data_sh;
    issue     = 1'b0;
    err       = 1'b0;
    if (valid_i) begin
      case (state)
        ST_IDLE: begin
          cnt_n = 2'd0;
          if (data_i == CH_R) begin
            rw_n    = 1'b0;
            state_n = ST_ADDR;
          end else if (data_i == CH_W) begin
            rw_n    = 1'b1;
            state_n = ST_ADDR;
          end else if (is_term(data_i)) begin
            state_n = ST_IDLE;  // stray terminators (e.g. LF after CR) are dropped
          end else begin
            err     = 1'b1;
            state_n = ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (is_hex) begin
            addr_sh_n = {addr_sh[11:0], nibble};
            cnt_n     = cnt + 2'd1;
            if (cnt == 2'd3) begin
              state_n = rw ? ST_DATA : ST_TERM;
            end else begin
              state_n = ST_ADDR;
            end
          end else begin
            err     = 1'b1;
            cnt_n   = 2'd0;
            state_n = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (is_hex) begin
            data_sh_n = {data_sh[11:0], nibble};
            cnt_n     = cnt + 2'd1;
            if (cnt == 2'd3) begin
              state_n = ST_TERM;
            end else begin
              state_n = ST_DATA;
            end
          end else begin
            err     = 1'b1;
            cnt_n   = 2'd0;
            state_n = ST_IDLE;
          end
        end
        ST_TERM: begin
          cnt_n   = 2'd0;
          state_n = ST_IDLE;
          if (is_term(data_i)) begin
            issue = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
        default: begin
          cnt_n   = 2'd0;
          state_n = ST_IDLE;
        end
      endcase
    end else begin
      state_n = state;
    end
  end

  // Parser state, counters and internal shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= 2'd0;
      rw      <= 1'b0;
      addr_sh <= 16'h0000;
      data_sh <= 16'h0000;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rw      <= rw_n;
      addr_sh <= addr_sh_n;
      data_sh <= data_sh_n;
    end
  end

  // Registered bus outputs: strobes for one cycle, payload only on issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid_o <= 1'b0;
      bus.err_o   <= 1'b0;
      bus.addr_o  <= 16'h0000;
      bus.wdata_o <= 16'h0000;
      bus.rw_o    <= 1'b0;
    end else begin
      bus.valid_o <= issue;
      bus.err_o   <= err;
      if (issue) begin
        bus.addr_o <= addr_sh;
        bus.rw_o   <= rw;
        if (rw) begin
          bus.wdata_o <= data_sh;
        end
      end
    end
  end

endmodule

// File: doc/bridge_rx.md
BRIDGE_RX -- requirements
Module: bridge_rx

Interface
REQ-001 Parameters: none; all widths are fixed by the 16-bit bus.
REQ-002 clk  input  1  single clock for all state; rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 data_i  input  8  received ASCII byte from the UART receiver.
REQ-005 valid_i  input  1  data_i is valid this cycle; at most one byte per cycle, no backpressure.
REQ-006 addr_o  output  16  bus address of the decoded transaction.
REQ-007 wdata_o  output  16  bus write data (write commands only).
REQ-008 rdata_o  output  16  bus read data seed, constant 0 (head of the core chain).
REQ-009 rw_o  output  1  1 = write, 0 = read.
REQ-010 valid_o  output  1  one-cycle strobe marking a complete bus transaction.
REQ-011 err_o  output  1  one-cycle strobe marking a discarded malformed command.

Function
REQ-012 The block shall accept read commands: 'R', then 4 hex digits (address, MSB nibble first), then a terminator.
REQ-013 The block shall accept write commands: 'W', then 4 hex address digits, then 4 hex data digits, then a terminator.
REQ-014 Hex digits shall be 0-9, A-F and a-f; the terminator shall be CR (0x0D) or LF (0x0A).
REQ-015 Cycles with valid_i=0 shall not change state; gaps of any length between bytes shall be legal.
REQ-016 The state machine shall have four states: IDLE, ADDR, DATA and TERM, plus a 2-bit nibble counter and a latched rw flag.
REQ-017 IDLE: 'R' shall go to ADDR with rw=0; 'W' shall go to ADDR with rw=1; CR or LF shall be ignored silently; any other byte shall pulse err_o and stay in IDLE.
REQ-018 ADDR: each hex digit shall shift into the address shift register; on the 4th digit the FSM shall go to TERM when rw=0 and to DATA when rw=1.
REQ-019 DATA: each hex digit shall shift into the data shift register; on the 4th digit the FSM shall go to TERM.
REQ-020 TERM: a terminator shall go to IDLE and issue the transaction.
REQ-021 Any unexpected byte in ADDR, DATA or TERM (non-hex or non-terminator, including 'R' or 'W') shall pulse err_o for one cycle, discard the partial command and return to IDLE; that byte shall not start a new command.
REQ-022 Latency: if the terminator is sampled at edge N, valid_o shall be high for exactly the cycle following edge N, and addr_o, wdata_o and rw_o shall be valid in that same cycle.
REQ-023 addr_o, wdata_o and rw_o shall change only when valid_o is issued and shall otherwise hold their last issued values; shift registers shall be internal.
REQ-024 A read command shall leave wdata_o unchanged.
REQ-025 valid_o and err_o shall never be high in the same cycle.
REQ-026 A new command byte arriving in the cycle valid_o is high shall be accepted normally (back-to-back commands).
REQ-027 CR followed by LF shall produce one transaction; the LF arriving in IDLE shall be ignored.
REQ-028 rdata_o shall be 0 at all times.

Reset
REQ-029 While rst_n=0: state=IDLE, nibble counter=0, shift registers=0, addr_o=0, wdata_o=0, rw_o=0, valid_o=0, err_o=0.
REQ-030 Reset asserted mid-command shall discard the partial command with no valid_o or err_o pulse.
REQ-031 The first byte sampled after rst_n deasserts shall be treated as arriving in IDLE.

Structure
REQ-032 A shared package shall hold the ASCII constants (R, W, CR, LF) and the state enumeration type.
REQ-033 Hex-digit classification and decoding shall live in one combinational sub-module, hex_char_decoder (byte in; is_hex and 4-bit nibble out).
REQ-034 The implementation shall be 120-400 lines of RTL, with no FIFO and no clock-domain crossing.

Verification
REQ-035 "R1234\r" -> one valid_o pulse one cycle after '\r'; addr_o=0x1234, rw_o=0, rdata_o=0.
REQ-036 "W00ffBEEF\n" with 3-cycle gaps between bytes -> one valid_o pulse; addr_o=0x00FF, wdata_o=0xBEEF, rw_o=1.
REQ-037 "R12G4\r" -> err_o pulses on 'G'; no valid_o; the following "R0001\r" -> addr_o=0x0001.
REQ-038 "R0010\r\nW0020ABCD\r" sent back-to-back with no idle cycles -> exactly two valid_o pulses (0x0010 read, then 0x0020/0xABCD write); the LF produces no err_o.
REQ-039 rst_n pulled low after "W12" -> outputs return to 0; the following "R0005\r" -> addr_o=0x0005 with no err_o.
REQ-040 "R12345\r" -> err_o pulses on '5' in TERM; no valid_o; addr_o keeps its previous value.
